// File: rtl/vga_mem_arb.sv
// rtl/vga_mem_arb.sv - display/host arbiter for a shared single-port pixel memory
// Optional write starvation guard enabled by defining VGA_ARB_STARVE_EN.
module vga_mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rvalid_q;
    logic                force_wr;

`ifdef VGA_ARB_STARVE_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = '0;
        if (wr_req && !wr_gnt) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Once the writer has waited STARVE_MAX cycles it takes the next slot.
    assign force_wr = (starve_cnt_q == CNT_W'(STARVE_MAX));
`else
    // Guard disabled: strict blank-based priority only.
    assign force_wr = (STARVE_MAX < 0);
`endif

    // Grants are combinational so a blank edge changes priority in the same cycle.
    always_comb begin
        disp_gnt    = 1'b0;
        wr_gnt      = 1'b0;
        state_d     = S_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rst_n) begin
            if (wr_req && (blank || !disp_req || force_wr)) begin
                wr_gnt      = 1'b1;
                state_d     = S_WR;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
            end else if (disp_req) begin
                disp_gnt    = 1'b1;
                state_d     = S_RD;
                mem_addr_d  = disp_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= (state_q == S_RD);
        end
    end

    assign mem_en      = (state_q != S_IDLE);
    assign mem_we      = (state_q == S_WR);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = rvalid_q;
    assign disp_rdata  = mem_rdata;

endmodule

// File: tb/tb_vga_mem_arb.sv
// tb/tb_vga_mem_arb.sv - self-checking bench for vga_mem_arb
module tb_vga_mem_arb;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int SMAX = 3;
    localparam int NRND = 400;
`ifdef VGA_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          blank;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    vga_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n), .blank(blank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    // Memory model: read data appears the cycle after a read strobe.
    always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? memf(mem_addr) : '0;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic d, input logic w,
                         input logic [AW-1:0] da, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        blank = b; disp_req = d; wr_req = w; disp_addr = da; wr_addr = wa; wr_data = wd;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dgnt"}, disp_gnt, 0);
        chk({tag, "_wgnt"}, wr_gnt, 0);
        chk({tag, "_en"}, mem_en, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_rv"}, disp_rvalid, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    typedef struct {
        logic b, d, w;
        logic eg_d, eg_w;
    } vec_t;

    vec_t tbl[8];

    logic          exp_en[NRND+3];
    logic          exp_we[NRND+3];
    logic [AW-1:0] exp_addr[NRND+3];
    logic [DW-1:0] exp_wd[NRND+3];
    logic          exp_rv[NRND+3];
    logic [DW-1:0] exp_rd[NRND+3];

    initial begin
        int ndg, nwg, cnt;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic mw, md;

        tbl[0] = '{0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0};
        tbl[2] = '{0, 0, 1, 0, 1};
        tbl[3] = '{0, 1, 1, 1, 0};
        tbl[4] = '{1, 0, 0, 0, 0};
        tbl[5] = '{1, 1, 0, 1, 0};
        tbl[6] = '{1, 0, 1, 0, 1};
        tbl[7] = '{1, 1, 1, 0, 1};

        // Reset with requests active: no grant may leak out.
        rst_n = 1'b0;
        drive(0, 1, 1, 16'h1234, 16'h4321, 8'h77);
        tick(); tick();
        chk_reset_vals("reset");

        // Single display read: grant, strobe, data return.
        rst_n = 1'b1;
        drive(0, 1, 0, 16'h0010, 16'h0000, 8'h00);
        #1;
        chk("rd_gnt_c1", disp_gnt, 1);
        chk("rd_wgnt_c1", wr_gnt, 0);
        tick();
        drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        #1;
        chk("rd_en_c2", mem_en, 1);
        chk("rd_we_c2", mem_we, 0);
        chk("rd_addr_c2", mem_addr, 16'h0010);
        chk("rd_rv_c2", disp_rvalid, 0);
        tick();
        chk("rd_rv_c3", disp_rvalid, 1);
        chk("rd_data_c3", disp_rdata, 8'hA5);
        chk("rd_en_c3", mem_en, 0);
        tick();
        chk("rd_rv_c4", disp_rvalid, 0);

        // Grant truth table, each entry followed by an idle cycle.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].b, tbl[i].d, tbl[i].w, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'(8'h30 + i));
            #1;
            chk($sformatf("tbl%0d_dgnt", i), disp_gnt, tbl[i].eg_d);
            chk($sformatf("tbl%0d_wgnt", i), wr_gnt, tbl[i].eg_w);
            tick();
            drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
            #1;
            chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].eg_d | tbl[i].eg_w);
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].eg_w);
            if (tbl[i].eg_w)
                chk($sformatf("tbl%0d_wd", i), mem_wdata, 8'(8'h30 + i));
            tick();
        end

        // Blank rising while both requests are held.
        drive(0, 1, 1, 16'h0400, 16'h0500, 8'h5C);
        #1;
        chk("edge_dgnt0", disp_gnt, 1);
        tick();
        blank = 1'b1;
        #1;
        chk("edge_wgnt1", wr_gnt, 1);
        chk("edge_dgnt1", disp_gnt, 0);
        tick();
        drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        tick();

`ifndef VGA_ARB_STARVE_EN
        // Active video, both held: display wins every cycle.
        ndg = 0; nwg = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 16'h0600 + 16'(i), 16'h0700, 8'h11);
            #1;
            ndg += int'(disp_gnt); nwg += int'(wr_gnt);
            tick();
        end
        chk("act_dgnts", ndg, 4);
        chk("act_wgnts", nwg, 0);
        // Blanking, both held: writer wins, each write visible next cycle.
        nwg = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 16'h0600, 16'h0800 + 16'(i), 8'(8'hC0 + i));
            #1;
            nwg += int'(wr_gnt);
            tick();
            chk($sformatf("blk%0d_we", i), mem_we, 1);
            chk($sformatf("blk%0d_addr", i), mem_addr, 16'h0800 + 16'(i));
            chk($sformatf("blk%0d_wd", i), mem_wdata, 8'(8'hC0 + i));
        end
        chk("blk_wgnts", nwg, 4);
`else
        // Active video, both held: writer gets one slot after SMAX waits.
        drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 1, 16'h0900, 16'h0A00, 8'h22);
            #1;
            chk($sformatf("stv%0d_wgnt", i), wr_gnt, (i % (SMAX + 1)) == SMAX);
            chk($sformatf("stv%0d_dgnt", i), disp_gnt, (i % (SMAX + 1)) != SMAX);
            tick();
        end
`endif
        drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        tick();

        // Reset right after a display grant cancels its rvalid.
        drive(0, 1, 0, 16'h0B0B, 16'h0000, 8'h00);
        #1;
        chk("rst_mid_gnt", disp_gnt, 1);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0000, 16'h0000, 8'h00);
        tick();
        chk_reset_vals("rst_mid");
        rst_n = 1'b1;
        tick();
        chk("rst_mid_rv_after", disp_rvalid, 0);

        // Randomised run against a scheduled-event reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < NRND + 3; c++) begin
            exp_en[c] = 0; exp_we[c] = 0; exp_addr[c] = '0; exp_wd[c] = '0;
            exp_rv[c] = 0; exp_rd[c] = '0;
        end
        m_addr = '0; m_wdata = '0; cnt = 0;
        for (int c = 0; c < NRND; c++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1),
                  AW'($urandom), AW'($urandom), DW'($urandom));
            mw = wr_req && (blank || !disp_req || (STARVE_ON && cnt == SMAX));
            md = disp_req && !mw;
            if (mw) begin
                m_addr = wr_addr; m_wdata = wr_data;
            end else if (md) begin
                m_addr = disp_addr;
                exp_rv[c+2] = 1'b1;
                exp_rd[c+2] = memf(disp_addr);
            end
            exp_en[c+1]   = mw | md;
            exp_we[c+1]   = mw;
            exp_addr[c+1] = m_addr;
            exp_wd[c+1]   = m_wdata;
            cnt = (wr_req && !mw) ? cnt + 1 : 0;
            #1;
            chk($sformatf("rnd%0d_dgnt", c), disp_gnt, md);
            chk($sformatf("rnd%0d_wgnt", c), wr_gnt, mw);
            chk($sformatf("rnd%0d_en", c), mem_en, exp_en[c]);
            chk($sformatf("rnd%0d_we", c), mem_we, exp_we[c]);
            chk($sformatf("rnd%0d_addr", c), mem_addr, exp_addr[c]);
            chk($sformatf("rnd%0d_wd", c), mem_wdata, exp_wd[c]);
            chk($sformatf("rnd%0d_rv", c), disp_rvalid, exp_rv[c]);
            if (exp_rv[c])
                chk($sformatf("rnd%0d_rd", c), disp_rdata, exp_rd[c]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vga_mem_arb.md
VGA_MEM_ARB -- requirements
Module: vga_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 16: address width of the shared pixel memory.
REQ-002 Parameter DATA_W, default 8: pixel width, matching the 8-bit rgb path.
REQ-003 Parameter STARVE_MAX, default 15: the maximum number of cycles a pending write waits before the starvation guard acts.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  pixel clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 blank  input  1  1 = outside the active video window (from the timing generator).
REQ-008 disp_req / disp_addr  input  1 / ADDR_W  display read request and address.
REQ-009 disp_gnt  output  1  one-cycle pulse when the display read is accepted.
REQ-010 disp_rvalid / disp_rdata  output  1 / DATA_W  read data return.
REQ-011 wr_req / wr_addr / wr_data  input  1 / ADDR_W / DATA_W  host write request.
REQ-012 wr_gnt  output  1  one-cycle pulse when the write is accepted.
REQ-013 mem_en / mem_we  output  1 / 1  memory access strobe and write enable, both registered.
REQ-014 mem_addr / mem_wdata  output  ADDR_W / DATA_W  registered memory address and write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0.

Function
REQ-016 FSM states: S_IDLE (no access this cycle), S_RD (display access issued), S_WR (write access issued); the next state is re-evaluated every cycle.
REQ-017 The arbiter grants at most one requester per cycle; each grant is a single-cycle pulse.
REQ-018 Requester contract: a requester holds its req and its address/data stable until it sees its gnt.
REQ-019 While blank=0, display has priority: disp_req=1 -> disp_gnt=1 and the next state is S_RD.
REQ-020 While blank=0, wr_gnt is asserted only when disp_req=0.
REQ-021 While blank=1, the writer has priority: wr_req=1 -> wr_gnt=1 and the next state is S_WR.
REQ-022 While blank=1, disp_gnt is asserted only when wr_req=0.
REQ-023 The cycle after a grant, mem_en=1 with the granted requester's address; mem_we=1 only for S_WR, with mem_wdata=wr_data.
REQ-024 When no access is issued, the next state is S_IDLE, mem_en=0, mem_we=0, and mem_addr and mem_wdata hold their previous values.
REQ-025 disp_rvalid=1 exactly 2 cycles after disp_gnt (1 cycle after mem_en), with disp_rdata=mem_rdata in that cycle.
REQ-026 Read latency is fixed at 2 cycles and back-to-back grants are allowed: throughput is 1 access per cycle.
REQ-027 Requests are sampled only in the grant cycle; a req that drops before its gnt is simply not served and does not block the other requester.
REQ-028 A blank edge that coincides with both requests being active takes effect in the same cycle: the priority follows the current blank value.

Reset
REQ-029 While rst_n=0 at a clock edge: the state is S_IDLE; disp_gnt, wr_gnt, mem_en, mem_we and disp_rvalid are 0; mem_addr, mem_wdata and the starvation counter are 0.
REQ-030 A reset mid-access cancels any pending disp_rvalid: no rvalid is emitted after reset for a grant issued before it.
REQ-031 The first grant is possible in the first cycle in which rst_n=1.

Configuration
REQ-032 Macro VGA_ARB_STARVE_EN.
REQ-033 With VGA_ARB_STARVE_EN defined, a STARVE_CNT counter increments each cycle that wr_req=1 and wr_gnt=0, and clears when wr_gnt=1 or wr_req=0.
REQ-034 With VGA_ARB_STARVE_EN defined, when STARVE_CNT=STARVE_MAX the writer wins the next arbitration regardless of blank, for exactly one grant.
REQ-035 Without VGA_ARB_STARVE_EN, strict priority per REQ-019..022 applies and no counter logic is generated.

Verification
REQ-036 Reset, then blank=0, disp_req=1 with disp_addr=0x0010 and mem_rdata=0xA5 -> disp_gnt at cycle 1; mem_en=1 and mem_addr=0x0010 at cycle 2; disp_rvalid=1 and disp_rdata=0xA5 at cycle 3.
REQ-037 blank=0, disp_req and wr_req both held high for 4 cycles, macro off -> 4 disp_gnt pulses and 0 wr_gnt.
REQ-038 Same stimulus as REQ-037 but blank=1 -> 4 wr_gnt pulses; mem_we=1, mem_addr=wr_addr and mem_wdata=wr_data each cycle after a grant.
REQ-039 VGA_ARB_STARVE_EN, STARVE_MAX=3, blank=0, both requests held -> 3 disp grants, 1 wr grant, then repeating.
REQ-040 disp_gnt issued, rst_n=0 in the next cycle -> disp_rvalid stays 0 and every output equals its reset value.
REQ-041 blank toggles 0->1 while both requests are held -> the grant switches from display to writer in the same cycle as the toggle.
